// File: rtl/demux1to2_stream.sv
// demux1to2_stream: 1-to-2 valid/ready stream demultiplexer.
// Each output owns one registered slot, so an accepted beat appears on its
// output one cycle after acceptance. A stalled output never blocks traffic to
// the other output. Each output also counts the beats its sink has taken.
// Optional packet lock: define DEMUX1TO2_STREAM_PKTLOCK_EN. A packet is a run
// of beats that ends with in_last=1. With the lock enabled, every beat of the
// packet follows the route chosen by its first beat.
module demux1to2_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic             in_last,
  output logic [WIDTH-1:0] y0_data,
  output logic             y0_valid,
  input  logic             y0_ready,
  output logic             y0_last,
  output logic [WIDTH-1:0] y1_data,
  output logic             y1_valid,
  input  logic             y1_ready,
  output logic             y1_last,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic             sel_eff;
  logic             accept;
  logic             drain0;
  logic             drain1;
  logic             slot_free;

  logic             y0_valid_q, y0_valid_d;
  logic [WIDTH-1:0] y0_data_q,  y0_data_d;
  logic             y0_last_q,  y0_last_d;
  logic             y1_valid_q, y1_valid_d;
  logic [WIDTH-1:0] y1_data_q,  y1_data_d;
  logic             y1_last_q,  y1_last_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

`ifdef DEMUX1TO2_STREAM_PKTLOCK_EN
  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCK0    = 2'd1,
    LOCK1    = 2'd2
  } lock_t;

  lock_t lock_q, lock_d;

  // Lock state register.
  always_ff @(posedge clk) begin
    if (!rst_n) lock_q <= UNLOCKED;
    else        lock_q <= lock_d;
  end

  // Next state: the first beat of a multi-beat packet locks the route, and the last beat releases it.
  always_comb begin
    lock_d = lock_q;
    if (accept) begin
      if (in_last)      lock_d = UNLOCKED;
      else if (sel_eff) lock_d = LOCK1;
      else              lock_d = LOCK0;
    end
  end

  // Route output: a locked packet ignores in_sel.
  always_comb begin
    case (lock_q)
      LOCK0:   sel_eff = 1'b0;
      LOCK1:   sel_eff = 1'b1;
      default: sel_eff = in_sel;
    endcase
  end
`else
  // Without packet lock every beat is routed by its own in_sel.
  always_comb sel_eff = in_sel;
`endif

  assign drain0 = y0_valid_q && y0_ready;
  assign drain1 = y1_valid_q && y1_ready;
  assign accept = in_valid && in_ready;

  // Accept when the selected slot is empty or is being drained this cycle; never during reset.
  always_comb begin
    slot_free = sel_eff ? (!y1_valid_q || y1_ready) : (!y0_valid_q || y0_ready);
    in_ready  = rst_n && slot_free;
  end

  // Slot 0: drain on handshake, reload on accept (a same-cycle drain and load gives back-to-back beats).
  always_comb begin
    y0_valid_d = y0_valid_q;
    y0_data_d  = y0_data_q;
    y0_last_d  = y0_last_q;
    if (drain0) y0_valid_d = 1'b0;
    if (accept && !sel_eff) begin
      y0_valid_d = 1'b1;
      y0_data_d  = in_data;
      y0_last_d  = in_last;
    end
  end

  // Slot 1: same behaviour as slot 0.
  always_comb begin
    y1_valid_d = y1_valid_q;
    y1_data_d  = y1_data_q;
    y1_last_d  = y1_last_q;
    if (drain1) y1_valid_d = 1'b0;
    if (accept && sel_eff) begin
      y1_valid_d = 1'b1;
      y1_data_d  = in_data;
      y1_last_d  = in_last;
    end
  end

  // Delivered-beat counters; they wrap naturally at 2^CNT_W.
  always_comb begin
    cnt0_d = cnt0_q + {{(CNT_W-1){1'b0}}, drain0};
    cnt1_d = cnt1_q + {{(CNT_W-1){1'b0}}, drain1};
  end

  // State registers; reset discards any held beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y0_valid_q <= 1'b0;
      y0_data_q  <= '0;
      y0_last_q  <= 1'b0;
      y1_valid_q <= 1'b0;
      y1_data_q  <= '0;
      y1_last_q  <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      y0_valid_q <= y0_valid_d;
      y0_data_q  <= y0_data_d;
      y0_last_q  <= y0_last_d;
      y1_valid_q <= y1_valid_d;
      y1_data_q  <= y1_data_d;
      y1_last_q  <= y1_last_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end

  assign y0_valid = y0_valid_q;
  assign y0_data  = y0_data_q;
  assign y0_last  = y0_last_q;
  assign y1_valid = y1_valid_q;
  assign y1_data  = y1_data_q;
  assign y1_last  = y1_last_q;
  assign cnt0     = cnt0_q;
  assign cnt1     = cnt1_q;

endmodule

// File: tb/tb_demux1to2_stream.sv
// Testbench for demux1to2_stream. It uses a behavioural queue model, a table of
// hand-derived vectors, multi-cycle corner sequences, and a randomized soak.
// The packet-lock expectations follow DEMUX1TO2_STREAM_PKTLOCK_EN.
module tb_demux1to2_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid, in_ready, in_sel, in_last;
  logic [7:0] y0_data, y1_data;
  logic       y0_valid, y0_ready, y0_last;
  logic       y1_valid, y1_ready, y1_last;
  logic [7:0] cnt0, cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one queue per output, each holding {last, data}.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int mc0, mc1;
  int pkt_dest;

  demux1to2_stream #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_last(in_last),
    .y0_data(y0_data), .y0_valid(y0_valid), .y0_ready(y0_ready), .y0_last(y0_last),
    .y1_data(y1_data), .y1_valid(y1_valid), .y1_ready(y1_ready), .y1_last(y1_last),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock. Inputs are already driven (at the negedge). The task checks
  // in_ready against the model, advances the model at the posedge, and checks
  // the outputs at the next negedge.
  task automatic step(output bit rdy_seen);
    int eff;
    bit exp_rdy, acc, dr0, dr1;
    #1;
    eff = (pkt_dest >= 0) ? pkt_dest : int'(in_sel);
    exp_rdy = rst_n && ((eff == 1) ? (q1.size() == 0 || y1_ready)
                                   : (q0.size() == 0 || y0_ready));
    rdy_seen = in_ready;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (!rst_n) begin
      q0.delete(); q1.delete(); mc0 = 0; mc1 = 0; pkt_dest = -1;
    end else begin
      acc = in_valid && exp_rdy;
      dr0 = (q0.size() != 0) && y0_ready;
      dr1 = (q1.size() != 0) && y1_ready;
      if (dr0) begin void'(q0.pop_front()); mc0 = (mc0 + 1) % 256; end
      if (dr1) begin void'(q1.pop_front()); mc1 = (mc1 + 1) % 256; end
      if (acc) begin
        if (eff == 1) q1.push_back({in_last, in_data});
        else          q0.push_back({in_last, in_data});
`ifdef DEMUX1TO2_STREAM_PKTLOCK_EN
        pkt_dest = in_last ? -1 : eff;
`endif
      end
    end
    @(negedge clk);
    check("y0_valid", 32'(y0_valid), 32'(q0.size() != 0));
    check("y1_valid", 32'(y1_valid), 32'(q1.size() != 0));
    if (q0.size() != 0) begin
      check("y0_data", 32'(y0_data), 32'(q0[0][7:0]));
      check("y0_last", 32'(y0_last), 32'(q0[0][8]));
    end
    if (q1.size() != 0) begin
      check("y1_data", 32'(y1_data), 32'(q1[0][7:0]));
      check("y1_last", 32'(y1_last), 32'(q1[0][8]));
    end
    check("cnt0", 32'(cnt0), 32'(mc0));
    check("cnt1", 32'(cnt1), 32'(mc1));
  endtask

  task automatic drive(input bit v, input bit s, input bit l, input logic [7:0] d,
                       input bit r0, input bit r1);
    in_valid = v; in_sel = s; in_last = l; in_data = d; y0_ready = r0; y1_ready = r1;
  endtask

  task automatic do_reset();
    bit r;
    rst_n = 1'b0;
    drive(0, 0, 0, 8'h00, 0, 0);
    step(r);
    step(r);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit v; bit sel; logic [7:0] d; bit r0; bit r1;
    bit rdy; bit y0v; logic [7:0] y0d; bit y1v; logic [7:0] y1d; int c0; int c1;
  } vec_t;

  vec_t tbl[11];

  initial begin
    bit r;
    rst_n = 1'b0; pkt_dest = -1; mc0 = 0; mc1 = 0;
    drive(0, 0, 0, 8'h00, 0, 0);
    @(negedge clk);

    // Reset state
    do_reset();
    check("reset_y0_data", 32'(y0_data), 32'h0);
    check("reset_y1_data", 32'(y1_data), 32'h0);
    check("reset_y0_last", 32'(y0_last), 32'h0);
    check("reset_y1_last", 32'(y1_last), 32'h0);

    // Table: single-beat packets, expected state after each edge
    tbl[0]  = '{1, 0, 8'hA5, 1, 1,  1, 1, 8'hA5, 0, 8'h00, 0, 0};
    tbl[1]  = '{0, 0, 8'h00, 1, 1,  1, 0, 8'h00, 0, 8'h00, 1, 0};
    tbl[2]  = '{1, 1, 8'h11, 1, 0,  1, 0, 8'h00, 1, 8'h11, 1, 0};
    tbl[3]  = '{1, 1, 8'h22, 1, 0,  0, 0, 8'h00, 1, 8'h11, 1, 0};
    tbl[4]  = '{1, 0, 8'h33, 0, 0,  1, 1, 8'h33, 1, 8'h11, 1, 0};
    tbl[5]  = '{1, 1, 8'h22, 1, 1,  1, 0, 8'h00, 1, 8'h22, 2, 1};
    tbl[6]  = '{1, 0, 8'h01, 1, 1,  1, 1, 8'h01, 0, 8'h00, 2, 2};
    tbl[7]  = '{1, 0, 8'h02, 1, 1,  1, 1, 8'h02, 0, 8'h00, 3, 2};
    tbl[8]  = '{1, 0, 8'h03, 1, 1,  1, 1, 8'h03, 0, 8'h00, 4, 2};
    tbl[9]  = '{1, 0, 8'h04, 1, 1,  1, 1, 8'h04, 0, 8'h00, 5, 2};
    tbl[10] = '{0, 0, 8'h00, 1, 1,  1, 0, 8'h00, 0, 8'h00, 6, 2};
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].v, tbl[i].sel, 1'b1, tbl[i].d, tbl[i].r0, tbl[i].r1);
      step(r);
      check($sformatf("tbl%0d_rdy", i), 32'(r), 32'(tbl[i].rdy));
      check($sformatf("tbl%0d_y0v", i), 32'(y0_valid), 32'(tbl[i].y0v));
      if (tbl[i].y0v) check($sformatf("tbl%0d_y0d", i), 32'(y0_data), 32'(tbl[i].y0d));
      check($sformatf("tbl%0d_y1v", i), 32'(y1_valid), 32'(tbl[i].y1v));
      if (tbl[i].y1v) check($sformatf("tbl%0d_y1d", i), 32'(y1_data), 32'(tbl[i].y1d));
      check($sformatf("tbl%0d_cnt0", i), 32'(cnt0), 32'(tbl[i].c0));
      check($sformatf("tbl%0d_cnt1", i), 32'(cnt1), 32'(tbl[i].c1));
    end

    // Counter wrap: 256 beats delivered to y1
    do_reset();
    for (int i = 0; i < 256; i++) begin
      drive(1, 1, 1, 8'(i), 1, 1);
      step(r);
    end
    check("wrap_cnt1_255", 32'(cnt1), 32'd255);
    drive(0, 0, 0, 8'h00, 1, 1);
    step(r);
    check("wrap_cnt1_0", 32'(cnt1), 32'd0);
    check("wrap_cnt0_0", 32'(cnt0), 32'd0);

    // Packet routing: sel 1,0,0 with last 0,0,1, then a single beat with sel 0
    do_reset();
    begin
      logic [7:0] pd[4];
      bit ps[4], pl[4], exp1[4];
      pd[0] = 8'h81; pd[1] = 8'h82; pd[2] = 8'h83; pd[3] = 8'h84;
      ps[0] = 1; ps[1] = 0; ps[2] = 0; ps[3] = 0;
      pl[0] = 0; pl[1] = 0; pl[2] = 1; pl[3] = 1;
`ifdef DEMUX1TO2_STREAM_PKTLOCK_EN
      exp1[0] = 1; exp1[1] = 1; exp1[2] = 1; exp1[3] = 0;
`else
      exp1[0] = 1; exp1[1] = 0; exp1[2] = 0; exp1[3] = 0;
`endif
      for (int i = 0; i < 4; i++) begin
        drive(1, ps[i], pl[i], pd[i], 1, 1);
        step(r);
        check($sformatf("pkt%0d_y1v", i), 32'(y1_valid), 32'(exp1[i]));
        check($sformatf("pkt%0d_y0v", i), 32'(y0_valid), 32'(!exp1[i]));
        check($sformatf("pkt%0d_data", i), 32'(exp1[i] ? y1_data : y0_data), 32'(pd[i]));
      end
    end

    // Mid-operation reset while y0 holds a stalled beat (and is locked if enabled)
    do_reset();
    drive(1, 0, 0, 8'h7E, 0, 0);
    step(r);
    drive(0, 0, 0, 8'h00, 0, 0);
    step(r);
    check("hold_y0v", 32'(y0_valid), 32'd1);
    check("hold_y0d", 32'(y0_data), 32'h7E);
    rst_n = 1'b0;
    step(r);
    check("rst_in_ready", 32'(r), 32'd0);
    check("rst_y0v", 32'(y0_valid), 32'd0);
    check("rst_cnt0", 32'(cnt0), 32'd0);
    rst_n = 1'b1;
    drive(1, 1, 1, 8'h5A, 0, 0);
    step(r);
    check("post_rst_y1v", 32'(y1_valid), 32'd1);
    check("post_rst_y1d", 32'(y1_data), 32'h5A);
    check("post_rst_y0v", 32'(y0_valid), 32'd0);

    // Randomized soak against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_sel   = ($urandom_range(0, 1) != 0);
      in_last  = ($urandom_range(0, 2) == 0);
      in_data  = 8'($urandom);
      y0_ready = ($urandom_range(0, 2) != 0);
      y1_ready = ($urandom_range(0, 2) != 0);
      step(r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demux1to2_stream.md
DEMUX1TO2_STREAM -- requirements
Module: demux1to2_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of every data port.
REQ-002 SHALL have parameter CNT_W, default 8, width of each per-output transfer counter.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 SHALL have port in_data  input  WIDTH  source beat payload.
REQ-006 SHALL have port in_valid  input  1  source beat present.
REQ-007 SHALL have port in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-008 SHALL have port in_sel  input  1  route select, 0 -> y0, 1 -> y1.
REQ-009 SHALL have port in_last  input  1  final beat of packet, used only with the lock feature.
REQ-010 SHALL have ports y0_data/y1_data  output  WIDTH  registered payload per output.
REQ-011 SHALL have ports y0_valid/y1_valid  output  1  output register holds a beat.
REQ-012 SHALL have ports y0_ready/y1_ready  input  1  sink accepts when valid && ready.
REQ-013 SHALL have ports y0_last/y1_last  output  1  registered copy of in_last.
REQ-014 SHALL have ports cnt0/cnt1  output  CNT_W  count of beats delivered to y0/y1 sinks.

Function
REQ-015 SHALL hold one beat per output in a registered slot; accepted beat appears on the chosen output exactly 1 cycle after acceptance.
REQ-016 SHALL drive in_ready = !yS_valid || yS_ready, where S is the effective select that cycle (combinational, no dependency on in_valid).
REQ-017 SHALL, on accept, load in_data and in_last into slot S and set yS_valid; the other slot SHALL be unaffected.
REQ-018 SHALL keep yS_valid, yS_data and yS_last stable while yS_valid && !yS_ready.
REQ-019 SHALL clear yS_valid after a sink handshake unless a new beat is loaded the same cycle; drain and load in the same cycle SHALL give a back-to-back beat with no bubble.
REQ-020 SHALL let traffic to the free output proceed while the other output is stalled.
REQ-021 SHALL use the in_sel sampled in the acceptance cycle; in_sel changes while not accepted SHALL have no effect.
REQ-022 SHALL increment cntN by 1 on every yN_valid && yN_ready; counters SHALL wrap from 2^CNT_W-1 to 0; both counters may increment in the same cycle.
REQ-023 SHALL never duplicate, drop or reorder beats per output.

Reset
REQ-024 SHALL, with rst_n low at a rising edge, set y0_valid=y1_valid=0, y0_data=y1_data=0, y0_last=y1_last=0, cnt0=cnt1=0, lock state UNLOCKED.
REQ-025 SHALL discard any held beat on mid-operation reset; in_ready SHALL be 0 during any cycle with rst_n low.
REQ-026 SHALL resume normal acceptance on the first rising edge after rst_n returns high.

Configuration
REQ-027 SHALL support macro DEMUX1TO2_STREAM_PKTLOCK_EN.
REQ-028 With the macro defined, SHALL implement FSM UNLOCKED/LOCK0/LOCK1: in UNLOCKED, S = in_sel; accepting a beat with in_last=0 moves to LOCK<S>; in LOCKn, S = n regardless of in_sel; accepting a beat with in_last=1 returns to UNLOCKED; a single-beat packet (in_last=1 in UNLOCKED) stays UNLOCKED.
REQ-029 Without the macro, SHALL have no FSM, S = in_sel every beat, in_last passed through to yS_last only.

Verification
REQ-030 Reset, then in_data=8'hA5, in_sel=0, in_valid=1 for one cycle, y0_ready=1 -> next cycle y0_valid=1, y0_data=8'hA5, y1_valid=0, cnt0=1 one cycle later.
REQ-031 y1_ready=0, send 8'h11 then 8'h22 with in_sel=1 -> 8'h11 held on y1, in_ready=0 for second beat until y1_ready=1; meanwhile 8'h33 with in_sel=0 accepted and appears on y0.
REQ-032 y0_ready=1 continuously, 4 beats 1,2,3,4 with in_sel=0 on consecutive cycles -> y0_valid high 4 consecutive cycles, data 1,2,3,4, cnt0=4.
REQ-033 Drive 256 beats to y1 with CNT_W=8 -> cnt1 returns to 0, cnt0 stays 0.
REQ-034 Macro defined: packet 3 beats, in_sel=1,0,0, in_last=0,0,1 -> all 3 on y1; next beat in_sel=0 goes to y0. Macro undefined: same stimulus -> beat 1 on y1, beats 2-3 on y0.
REQ-035 Reset asserted while y0 holds 8'h7E stalled and FSM in LOCK0 -> next cycle y0_valid=0, cnt0=0, a beat with in_sel=1 then routes to y1.
